// File: rtl/kbd_matrix_scanner_pkg.sv
// Shared definitions for the keyboard matrix scanner and its keycode consumer:
// scan FSM state encodings and the event field width helpers.
package kbd_matrix_scanner_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SAMPLE = 3'd2,
      REPORT = 3'd3,
      NEXT   = 3'd4
   } scan_state_t;

   function automatic int ev_row_width(input int rows);
      return $clog2(rows);
   endfunction

   function automatic int ev_col_width(input int cols);
      return $clog2(cols);
   endfunction

endpackage

// File: rtl/kbd_matrix_scanner_counter.sv
// Free-running modulo counter; max_val flags the last count before wrap.
// Used by the scanner as the row settle timer.
module counter #(
   parameter int MAX_VALUE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic max_val
);

   localparam int W = $clog2(MAX_VALUE);
   localparam logic [W-1:0] LAST = W'(MAX_VALUE - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + W'(1);
      end
   end

   assign max_val = (count == LAST);

endmodule

// File: rtl/kbd_matrix_scanner.sv
// Keyboard matrix scan sequencer: drives rows one at a time, debounces each key
// across scans and reports press/release events over a valid/ready handshake.
module kbd_matrix_scanner
   import kbd_matrix_scanner_pkg::*;
#(
   parameter int ROWS           = 8,
   parameter int COLS           = 8,
   parameter int SETTLE_CYCLES  = 16,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   output logic [ROWS-1:0]         row_n,
   input  logic [COLS-1:0]         col_n,
   output logic                    ev_valid,
   input  logic                    ev_ready,
   output logic                    ev_pressed,
   output logic [$clog2(ROWS)-1:0] ev_row,
   output logic [$clog2(COLS)-1:0] ev_col,
   output logic                    scan_done
);

   localparam int RW  = ev_row_width(ROWS);
   localparam int CW  = ev_col_width(COLS);
   localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DBW-1:0] DB_MAX   = DBW'(DEBOUNCE_SCANS);
   localparam logic [RW-1:0]  LAST_ROW = RW'(ROWS - 1);
   localparam logic [CW-1:0]  LAST_COL = CW'(COLS - 1);

   scan_state_t state, state_nx;

   logic [RW-1:0]   row;
   logic [CW-1:0]   col, col_nx;
   logic [COLS-1:0] col_meta, col_sync, pressed;
   logic [COLS-1:0] stable [ROWS];
   logic [DBW-1:0]  db_cnt [ROWS][COLS];
   logic [DBW-1:0]  db_upd [COLS];
   logic            settle_clr, settle_max, col_step;

   // Columns idle high (released) so the synchronizer resets to all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_meta <= '1;
         col_sync <= '1;
      end else begin
         col_meta <= col_n;
         col_sync <= col_meta;
      end
   end

   // settle_clr is a flop, so the timer's async clear never sees a glitch.
   counter #(
      .MAX_VALUE(SETTLE_CYCLES)
   ) u_settle (
      .clk     (clk),
      .rst     (rst | settle_clr),
      .en      (state == DRIVE),
      .max_val (settle_max)
   );

   assign pressed  = ~col_sync;
   assign col_nx   = col + CW'(1);
   assign col_step = (state == REPORT) && (!ev_valid || ev_ready);

   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         db_upd[c] = '0;
         if (pressed[c] != stable[row][c]) begin
            db_upd[c] = (db_cnt[row][c] == DB_MAX) ? DB_MAX : db_cnt[row][c] + DBW'(1);
         end
      end
   end

   always_comb begin
      state_nx  = state;
      row_n     = '1;
      scan_done = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nx = DRIVE;
         end
         DRIVE: begin
            row_n[row] = 1'b0;
            if (settle_max) state_nx = SAMPLE;
         end
         SAMPLE: begin
            row_n[row] = 1'b0;
            state_nx   = REPORT;
         end
         REPORT: begin
            if (col_step && (col == LAST_COL)) state_nx = NEXT;
         end
         NEXT: begin
            scan_done = (row == LAST_ROW);
            state_nx  = en ? DRIVE : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         settle_clr <= 1'b1;
      end else begin
         state      <= state_nx;
         settle_clr <= (state_nx != DRIVE);
      end
   end

   // Event fields look one column ahead so back-to-back events need no gap cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row        <= '0;
         col        <= '0;
         ev_valid   <= 1'b0;
         ev_pressed <= 1'b0;
         ev_row     <= '0;
         ev_col     <= '0;
         for (int r = 0; r < ROWS; r++) begin
            stable[r] <= '0;
            for (int c = 0; c < COLS; c++) begin
               db_cnt[r][c] <= '0;
            end
         end
      end else begin
         case (state)
            SAMPLE: begin
               for (int c = 0; c < COLS; c++) begin
                  db_cnt[row][c] <= db_upd[c];
               end
               col        <= '0;
               ev_row     <= row;
               ev_col     <= '0;
               ev_pressed <= ~stable[row][0];
               ev_valid   <= (db_upd[0] == DB_MAX);
            end
            REPORT: begin
               if (ev_valid && ev_ready) begin
                  stable[row][col] <= ~stable[row][col];
                  db_cnt[row][col] <= '0;
               end
               if (col_step) begin
                  if (col == LAST_COL) begin
                     ev_valid <= 1'b0;
                  end else begin
                     col        <= col_nx;
                     ev_col     <= col_nx;
                     ev_pressed <= ~stable[row][col_nx];
                     ev_valid   <= (db_cnt[row][col_nx] == DB_MAX);
                  end
               end
            end
            NEXT: begin
               row <= ((row == LAST_ROW) || !en) ? '0 : row + RW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_kbd_matrix_scanner.sv
// Scoreboard bench for kbd_matrix_scanner on a 4x4 matrix: directed key
// scenarios push expected events, a monitor checks every handshake.
module tb_kbd_matrix_scanner;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic       ev_valid;
   logic       ev_ready;
   logic       ev_pressed;
   logic [1:0] ev_row;
   logic [1:0] ev_col;
   logic       scan_done;

   logic [3:0] keys [4];

   typedef struct {
      int row;
      int col;
      int pressed;
      int scan;
   } ev_t;

   ev_t exp_q [$];
   ev_t exp_ev;
   int  checks     = 0;
   int  failures   = 0;
   int  scan_count = 0;

   kbd_matrix_scanner #(
      .ROWS           (4),
      .COLS           (4),
      .SETTLE_CYCLES  (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .row_n      (row_n),
      .col_n      (col_n),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_pressed (ev_pressed),
      .ev_row     (ev_row),
      .ev_col     (ev_col),
      .scan_done  (scan_done)
   );

   always #5 clk = ~clk;

   // A pressed key pulls its column low only while its row is driven.
   always_comb begin
      col_n = '1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row_n[r] && keys[r][c]) col_n[c] = 1'b0;
         end
      end
   end

   task automatic check_output(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         scan_count = 0;
      end else begin
         if (ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_event actual=row%0d/col%0d/pressed%0d required=none",
                        ev_row, ev_col, ev_pressed);
            end else begin
               exp_ev = exp_q.pop_front();
               check_output("ev_row", int'(ev_row), exp_ev.row);
               check_output("ev_col", int'(ev_col), exp_ev.col);
               check_output("ev_pressed", int'(ev_pressed), exp_ev.pressed);
               check_output("ev_scan", scan_count, exp_ev.scan);
            end
         end
         if (scan_done) scan_count++;
      end
   end

   task automatic push_event(input int r, input int c, input int p, input int s);
      ev_t e;
      e.row = r; e.col = c; e.pressed = p; e.scan = s;
      exp_q.push_back(e);
   endtask

   task automatic apply_reset();
      rst      = 1'b1;
      en       = 1'b0;
      ev_ready = 1'b1;
      for (int r = 0; r < 4; r++) keys[r] = '0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic start_scan();
      @(posedge clk);
      #1 en = 1'b1;
   endtask

   task automatic wait_scans(input int n, input string name);
      for (int i = 0; i < 400 && scan_count < n; i++) @(negedge clk);
      check_output(name, int'(scan_count >= n), 1);
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 200 && !ev_valid; i++) @(negedge clk);
      check_output(name, int'(ev_valid), 1);
   endtask

   task automatic apply_stimulus();
      int exp_row_n;
      int pos;
      int hits_row1;
      int hits_row2;

      // Reset values, then a clean two-scan pass with row_n timing checked every cycle.
      apply_reset();
      @(negedge clk);
      check_output("reset_row_n", int'(row_n), 15);
      check_output("reset_ev_valid", int'(ev_valid), 0);
      check_output("reset_ev_pressed", int'(ev_pressed), 0);
      check_output("reset_ev_row", int'(ev_row), 0);
      check_output("reset_ev_col", int'(ev_col), 0);
      check_output("reset_scan_done", int'(scan_done), 0);
      start_scan();
      for (int k = 0; k <= 80; k++) begin
         @(negedge clk);
         exp_row_n = 15;
         if (k > 0) begin
            pos = (k - 1) % 40;
            if ((pos % 10) <= 4) exp_row_n = 15 & ~(1 << (pos / 10));
         end
         check_output("a_row_n", int'(row_n), exp_row_n);
         check_output("a_scan_done", int'(scan_done), int'(k > 0 && (k % 40) == 0));
      end
      check_output("a_no_events", int'(ev_valid), 0);

      // Held key at (2,1): press reported in scan 1, release two scans after letting go.
      apply_reset();
      keys[2][1] = 1'b1;
      push_event(2, 1, 1, 1);
      start_scan();
      wait_scans(2, "b_wait_press");
      keys[2][1] = 1'b0;
      push_event(2, 1, 0, 3);
      wait_scans(5, "b_wait_release");
      check_output("b_drained", exp_q.size(), 0);

      // One-scan bounce at (1,3): counter rises to 1 then clears, nothing reported.
      apply_reset();
      keys[1][3] = 1'b1;
      start_scan();
      wait_scans(1, "c_wait_scan0");
      check_output("c_db_after_bounce", int'(dut.db_cnt[1][3]), 1);
      keys[1][3] = 1'b0;
      wait_scans(2, "c_wait_scan1");
      check_output("c_db_cleared", int'(dut.db_cnt[1][3]), 0);
      wait_scans(3, "c_wait_scan2");

      // Two presses in row 0 under backpressure: col 0 held, then col 0 before col 2.
      apply_reset();
      ev_ready   = 1'b0;
      keys[0][0] = 1'b1;
      keys[0][2] = 1'b1;
      push_event(0, 0, 1, 1);
      push_event(0, 2, 1, 1);
      start_scan();
      wait_valid("d_valid_seen");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_output("d_hold_valid", int'(ev_valid), 1);
         check_output("d_hold_col", int'(ev_col), 0);
         check_output("d_hold_row", int'(ev_row), 0);
         check_output("d_hold_pressed", int'(ev_pressed), 1);
         check_output("d_hold_row_n", int'(row_n), 15);
      end
      @(posedge clk);
      #1 ev_ready = 1'b1;
      @(negedge clk);
      check_output("d_first_col", int'(ev_col), 0);
      @(negedge clk);
      check_output("d_gap_valid", int'(ev_valid), 0);
      @(negedge clk);
      check_output("d_second_valid", int'(ev_valid), 1);
      check_output("d_second_col", int'(ev_col), 2);
      wait_scans(2, "d_wait_end");
      check_output("d_drained", exp_q.size(), 0);

      // Disable during row 1: that row completes, then idle; restart begins at row 0.
      apply_reset();
      start_scan();
      for (int i = 0; i < 100 && row_n != 4'b1101; i++) @(negedge clk);
      check_output("e_row1_reached", int'(row_n), 13);
      @(posedge clk);
      #1 en = 1'b0;
      hits_row1 = 0;
      hits_row2 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (row_n == 4'b1101) hits_row1++;
         if (row_n == 4'b1011) hits_row2++;
      end
      check_output("e_row1_completed", hits_row1, 4);
      check_output("e_row2_not_driven", hits_row2, 0);
      check_output("e_idle_row_n", int'(row_n), 15);
      check_output("e_no_scan_done", scan_count, 0);
      start_scan();
      @(negedge clk);
      check_output("e_restart_delay", int'(row_n), 15);
      @(negedge clk);
      check_output("e_restart_row0", int'(row_n), 14);

      // Reset while an event is pending: outputs clear at once, event never appears.
      apply_reset();
      ev_ready   = 1'b0;
      keys[3][3] = 1'b1;
      start_scan();
      wait_valid("f_valid_seen");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("f_rst_ev_valid", int'(ev_valid), 0);
      check_output("f_rst_row_n", int'(row_n), 15);
      check_output("f_rst_ev_col", int'(ev_col), 0);
      check_output("f_rst_ev_row", int'(ev_row), 0);
      keys[3][3] = 1'b0;
      ev_ready   = 1'b1;
      en         = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      start_scan();
      wait_scans(2, "f_wait_end");
      check_output("f_drained", exp_q.size(), 0);
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      ev_ready = 1'b1;
      for (int r = 0; r < 4; r++) keys[r] = '0;
      apply_stimulus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
